// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 round-robin lock arbiter.
//   lock_state_e : bus-lock FSM states (IDLE, LOCKED).
//   idx_width()  : bit width of a master index (pointer/owner), minimum 1.
package l2_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational rotating-priority selector.
// Picks the first set bit of elig_i scanning ptr_i, ptr_i+1, ... wrapping at N-1.
//   elig_i    in  [N]  : eligibility vector
//   ptr_i     in  [PW] : highest-priority index (must be < N)
//   win_oh_o  out [N]  : one-hot winner (all zero when none)
//   win_idx_o out [PW] : winner index (0 when none)
//   valid_o   out      : any eligible bit set
module rr_prio_select #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_oh_o,
    output logic [PW-1:0] win_idx_o,
    output logic          valid_o
);

    logic [2*N-1:0] dbl;

    always_comb begin
        // Lower copy keeps only indices at/after ptr, upper copy is unmasked,
        // so the lowest set bit of the 2N vector is the rotating-priority winner.
        dbl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            dbl[i]     = elig_i[i] && (PW'(i) >= ptr_i);
            dbl[N + i] = elig_i[i];
        end

        valid_o   = 1'b0;
        win_idx_o = '0;
        win_oh_o  = '0;
        for (int unsigned i = 0; i < 2 * N; i++) begin
            if (!valid_o && dbl[i]) begin
                valid_o   = 1'b1;
                win_idx_o = PW'(i % N);
            end
        end
        if (valid_o) begin
            win_oh_o[win_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_rr_lock_arbiter.sv
// Round-robin arbiter sharing one L2 memory port among N_MASTER requesters,
// with per-master bus lock (up to MAX_LOCK back-to-back transactions) and an
// outstanding-transaction limiter (MAX_OUTSTANDING pending responses).
//   clk, rst_n          : clock, asynchronous active-low reset
//   data_*_i / gnt_o    : master-side request vectors and per-master grant
//   data_*_o / gnt_i    : forwarded request to memory and memory accept
//   data_r_valid_i/ID_i : response from memory; data_r_valid_o routes it one-hot
//   outstanding_o       : number of accepted transactions awaiting a response
module l2_rr_lock_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned N_MASTER        = 16,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = N_MASTER,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned MAX_LOCK        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]                  data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
    input  logic [N_MASTER-1:0][ID_WIDTH-1:0]    data_ID_i,
    input  logic [N_MASTER-1:0]                  data_lock_i,
    output logic [N_MASTER-1:0]                  data_gnt_o,
    output logic                                 data_req_o,
    output logic [ADDR_WIDTH-1:0]                data_add_o,
    output logic                                 data_wen_o,
    output logic [DATA_WIDTH-1:0]                data_wdata_o,
    output logic [BE_WIDTH-1:0]                  data_be_o,
    output logic [ID_WIDTH-1:0]                  data_ID_o,
    input  logic                                 data_gnt_i,
    input  logic                                 data_r_valid_i,
    input  logic [ID_WIDTH-1:0]                  data_r_ID_i,
    output logic [N_MASTER-1:0]                  data_r_valid_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

    localparam int unsigned PW = idx_width(N_MASTER);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned LW = $clog2(MAX_LOCK + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_MASTER - 1);

    lock_state_e         state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]       count_q, count_d;

    logic [N_MASTER-1:0] owner_oh;
    logic [N_MASTER-1:0] elig;
    logic [N_MASTER-1:0] win_oh;
    logic [PW-1:0]       win_idx;
    logic                win_valid;
    logic                accept;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    // Eligibility uses only registered state, keeping gnt/r_valid off the req path.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        elig              = '0;
        if (count_q < CW'(MAX_OUTSTANDING)) begin
            elig = (state_q == LOCKED) ? (data_req_i & owner_oh) : data_req_i;
        end
    end

    rr_prio_select #(
        .N  (N_MASTER),
        .PW (PW)
    ) u_sel (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .valid_o   (win_valid)
    );

    assign accept = win_valid && data_gnt_i;

    always_comb begin
        data_req_o   = win_valid;
        data_gnt_o   = data_gnt_i ? win_oh : '0;
        data_add_o   = '0;
        data_wen_o   = 1'b0;
        data_wdata_o = '0;
        data_be_o    = '0;
        data_ID_o    = '0;
        if (win_valid) begin
            data_add_o   = data_add_i[win_idx];
            data_wen_o   = data_wen_i[win_idx];
            data_wdata_o = data_wdata_i[win_idx];
            data_be_o    = data_be_i[win_idx];
            data_ID_o    = data_ID_i[win_idx];
        end
    end

    assign data_r_valid_o = data_r_valid_i ? data_r_ID_i[N_MASTER-1:0] : '0;
    assign outstanding_o  = count_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d = next_idx(win_idx);
                    if (data_lock_i[win_idx] && (MAX_LOCK > 1)) begin
                        state_d    = LOCKED;
                        owner_d    = win_idx;
                        lock_cnt_d = LW'(1);
                    end
                end
            end
            LOCKED: begin
                // Owner dropping its request releases the lock; the pointer
                // stayed frozen during the tenure and resumes after the owner.
                if (!data_req_i[owner_q]) begin
                    state_d    = IDLE;
                    ptr_d      = next_idx(owner_q);
                    lock_cnt_d = '0;
                end else if (accept) begin
                    if (!data_lock_i[owner_q] || (lock_cnt_q == LW'(MAX_LOCK - 1))) begin
                        state_d    = IDLE;
                        ptr_d      = next_idx(owner_q);
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (accept && !data_r_valid_i) begin
            count_d = count_q + 1'b1;
        end else if (!accept && data_r_valid_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_l2_rr_lock_arbiter.sv
module tb_l2_rr_lock_arbiter;

    localparam int unsigned N  = 16;
    localparam int unsigned SN = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Main instance: N=16, MAX_OUTSTANDING=2, MAX_LOCK=4
    logic [N-1:0]             m_req, m_wen, m_lock, m_gnt_o, m_rv_o;
    logic [N-1:0][31:0]       m_add;
    logic [N-1:0][63:0]       m_wdata;
    logic [N-1:0][7:0]        m_be;
    logic [N-1:0][N-1:0]      m_id;
    logic                     m_req_o, m_wen_o, m_gnt_i, m_rv_i;
    logic [31:0]              m_add_o;
    logic [63:0]              m_wdata_o;
    logic [7:0]               m_be_o;
    logic [N-1:0]             m_id_o, m_rid;
    logic [1:0]               m_outst;

    // Small instance: N=5 (non power of two), MAX_OUTSTANDING=4, MAX_LOCK=8
    logic [SN-1:0]            s_req, s_wen, s_lock, s_gnt_o, s_rv_o;
    logic [SN-1:0][7:0]       s_add;
    logic [SN-1:0][7:0]       s_wdata;
    logic [SN-1:0][0:0]       s_be;
    logic [SN-1:0][SN-1:0]    s_id;
    logic                     s_req_o, s_wen_o, s_gnt_i, s_rv_i;
    logic [7:0]               s_add_o;
    logic [7:0]               s_wdata_o;
    logic [0:0]               s_be_o;
    logic [SN-1:0]            s_id_o, s_rid;
    logic [2:0]               s_outst;

    l2_rr_lock_arbiter #(
        .N_MASTER        (N),
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (64),
        .MAX_OUTSTANDING (2),
        .MAX_LOCK        (4)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (m_req),
        .data_add_i     (m_add),
        .data_wen_i     (m_wen),
        .data_wdata_i   (m_wdata),
        .data_be_i      (m_be),
        .data_ID_i      (m_id),
        .data_lock_i    (m_lock),
        .data_gnt_o     (m_gnt_o),
        .data_req_o     (m_req_o),
        .data_add_o     (m_add_o),
        .data_wen_o     (m_wen_o),
        .data_wdata_o   (m_wdata_o),
        .data_be_o      (m_be_o),
        .data_ID_o      (m_id_o),
        .data_gnt_i     (m_gnt_i),
        .data_r_valid_i (m_rv_i),
        .data_r_ID_i    (m_rid),
        .data_r_valid_o (m_rv_o),
        .outstanding_o  (m_outst)
    );

    l2_rr_lock_arbiter #(
        .N_MASTER        (SN),
        .ADDR_WIDTH      (8),
        .DATA_WIDTH      (8),
        .MAX_OUTSTANDING (4),
        .MAX_LOCK        (8)
    ) u_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (s_req),
        .data_add_i     (s_add),
        .data_wen_i     (s_wen),
        .data_wdata_i   (s_wdata),
        .data_be_i      (s_be),
        .data_ID_i      (s_id),
        .data_lock_i    (s_lock),
        .data_gnt_o     (s_gnt_o),
        .data_req_o     (s_req_o),
        .data_add_o     (s_add_o),
        .data_wen_o     (s_wen_o),
        .data_wdata_o   (s_wdata_o),
        .data_be_o      (s_be_o),
        .data_ID_o      (s_id_o),
        .data_gnt_i     (s_gnt_i),
        .data_r_valid_i (s_rv_i),
        .data_r_ID_i    (s_rid),
        .data_r_valid_o (s_rv_o),
        .outstanding_o  (s_outst)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect main master k to be selected with data_gnt_i=1.
    task automatic m_win(input string tag, input int unsigned k);
        logic [N-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        chk({tag, " req_o"}, 64'(m_req_o), 64'd1);
        chk({tag, " gnt"},   64'(m_gnt_o), 64'(oh));
        chk({tag, " add"},   64'(m_add_o), 64'(m_add[k]));
    endtask

    task automatic s_win(input string tag, input int unsigned k);
        logic [SN-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        chk({tag, " req_o"}, 64'(s_req_o), 64'd1);
        chk({tag, " gnt"},   64'(s_gnt_o), 64'(oh));
        chk({tag, " id"},    64'(s_id_o),  64'(s_id[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int unsigned exp_a [6] = '{0, 3, 5, 0, 3, 5};

    initial begin
        rst_n   = 1'b0;
        m_req   = '0; m_lock = '0; m_gnt_i = 1'b0; m_rv_i = 1'b0; m_rid = '0;
        s_req   = '0; s_lock = '0; s_gnt_i = 1'b0; s_rv_i = 1'b0; s_rid = '0;
        for (int k = 0; k < N; k++) begin
            m_add[k]   = 32'h1000_0000 + 32'(k);
            m_wdata[k] = 64'hDA7A_0000_0000_0000 | 64'(k);
            m_be[k]    = 8'hFF ^ 8'(k);
            m_wen[k]   = k[0];
            m_id[k]    = '0;
            m_id[k][k] = 1'b1;
        end
        for (int k = 0; k < SN; k++) begin
            s_add[k]   = 8'h40 + 8'(k);
            s_wdata[k] = 8'hE0 + 8'(k);
            s_be[k]    = 1'b1;
            s_wen[k]   = k[0];
            s_id[k]    = '0;
            s_id[k][k] = 1'b1;
        end

        // Reset state; routing works even in reset
        m_rv_i = 1'b1; m_rid = 16'h0040;
        repeat (3) @(negedge clk);
        #1;
        chk("reset outst",   64'(m_outst), 64'd0);
        chk("reset req_o",   64'(m_req_o), 64'd0);
        chk("reset gnt",     64'(m_gnt_o), 64'd0);
        chk("reset s_outst", 64'(s_outst), 64'd0);
        chk("route 0040",    64'(m_rv_o),  64'h0040);
        rst_n = 1'b1;
        tick();

        // Round-robin fairness: masters 0,3,5 with responses every cycle
        m_req = 16'b0000_0000_0010_1001; m_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            m_win($sformatf("A%0d", i), exp_a[i]);
            chk($sformatf("A%0d rv_o", i), 64'(m_rv_o), 64'h0040);
            if (i == 2) begin
                chk("A2 wdata", m_wdata_o, m_wdata[5]);
                chk("A2 be",    64'(m_be_o),  64'(m_be[5]));
                chk("A2 wen",   64'(m_wen_o), 64'(m_wen[5]));
                chk("A2 id",    64'(m_id_o),  64'(m_id[5]));
            end
            tick();
        end
        m_req = '0;
        tick();

        // Lock tenure: M2 lock=1,1,0 while M1 requests (ptr starts at 6)
        m_req = 16'h0004; m_lock = 16'h0004;
        #1; m_win("B1", 2); tick();
        m_req = 16'h0006;
        #1; m_win("B2", 2); tick();
        m_lock = '0;
        #1; m_win("B3", 2); tick();
        #1; m_win("B4", 1); tick();
        m_req = '0;
        tick();

        // Forced release after MAX_LOCK=4 grants; ptr=3 lets M3 beat M2
        m_req = 16'h000C; m_lock = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            #1; m_win($sformatf("C%0d", i + 1), 2); tick();
        end
        #1; m_win("C5", 3); tick();
        m_req = '0; m_lock = '0;
        tick();

        // Owner drops request: nothing issued that cycle, released next
        m_req = 16'h0010; m_lock = 16'h0010;
        #1; m_win("D1", 4); tick();
        m_req = 16'h0040; m_lock = '0;
        #1;
        chk("D2 req_o", 64'(m_req_o), 64'd0);
        chk("D2 gnt",   64'(m_gnt_o), 64'd0);
        tick();
        #1; m_win("D3", 6); tick();
        m_req = '0;
        tick();

        // Outstanding limit MAX_OUTSTANDING=2
        m_rv_i = 1'b0; m_req = 16'h0080;
        #1; m_win("E1", 7); chk("E1 outst", 64'(m_outst), 64'd0); tick();
        #1; m_win("E2", 7); chk("E2 outst", 64'(m_outst), 64'd1); tick();
        #1;
        chk("E3 req_o", 64'(m_req_o), 64'd0);
        chk("E3 gnt",   64'(m_gnt_o), 64'd0);
        chk("E3 outst", 64'(m_outst), 64'd2);
        tick();
        m_rv_i = 1'b1; m_rid = 16'h0080;
        #1;
        chk("E4 req_o", 64'(m_req_o), 64'd0);
        chk("E4 rv_o",  64'(m_rv_o),  64'h0080);
        chk("E4 outst", 64'(m_outst), 64'd2);
        tick();
        #1; m_win("E5", 7); chk("E5 outst", 64'(m_outst), 64'd1); tick();
        m_rv_i = 1'b0;
        #1; chk("E6 outst", 64'(m_outst), 64'd1); m_win("E6", 7); tick();
        m_req = '0; m_rv_i = 1'b1;
        #1; chk("E7 outst", 64'(m_outst), 64'd2); tick();
        tick();
        m_rv_i = 1'b0;
        #1; chk("E8 outst", 64'(m_outst), 64'd0);

        // Memory stall: M4 requesting, gnt_i=0 for 5 cycles (ptr is 8)
        m_req = 16'h0010; m_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("F%0d req_o", i), 64'(m_req_o), 64'd1);
            chk($sformatf("F%0d gnt", i),   64'(m_gnt_o), 64'd0);
            chk($sformatf("F%0d add", i),   64'(m_add_o), 64'(m_add[4]));
            chk($sformatf("F%0d outst", i), 64'(m_outst), 64'd0);
            tick();
        end
        // ptr still 8: M4 wins over M6
        m_gnt_i = 1'b1; m_req = 16'h0050;
        #1; m_win("F5", 4); tick();
        m_req = '0; m_rv_i = 1'b1;
        tick();
        m_rv_i = 1'b0;

        // Small instance: pointer wrap 4 -> 0 for N=5
        s_gnt_i = 1'b1; s_req = 5'b10000;
        #1; s_win("S1", 4); tick();
        s_req = 5'b10001;
        #1; s_win("S2", 0); tick();
        s_req = 5'b00010; s_lock = 5'b00010;
        #1; s_win("S3", 1); tick();
        // Locked to M1 with count 3, memory stalled; ptr=2 would otherwise pick M2
        s_req = 5'b00110; s_gnt_i = 1'b0;
        #1;
        chk("S4 req_o", 64'(s_req_o), 64'd1);
        chk("S4 id",    64'(s_id_o),  64'(s_id[1]));
        chk("S4 outst", 64'(s_outst), 64'd3);
        // Asynchronous reset mid-lock
        #1 rst_n = 1'b0;
        #1;
        chk("S5 async outst", 64'(s_outst), 64'd0);
        tick();
        rst_n = 1'b1;
        s_req = 5'b00100;
        #1;
        chk("S6 req_o", 64'(s_req_o), 64'd1);
        chk("S6 id",    64'(s_id_o),  64'(s_id[2]));
        chk("S6 outst", 64'(s_outst), 64'd0);
        tick();
        s_req = '0; s_rv_i = 1'b1; s_rid = 5'b00100;
        #1; chk("S7 rv_o", 64'(s_rv_o), 64'(5'b00100));
        tick();
        s_rv_i = 1'b0;
        #1; chk("S8 outst", 64'(s_outst), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/l2_rr_lock_arbiter.md
# l2_rr_lock_arbiter

Sequential round-robin arbiter sharing one L2 memory port among `N_MASTER` requesters, on the request side of the L2 crossbar just ahead of a memory bank. It adds three things to a plain arbitration tree. A fair rotating-priority pointer. A per-master bus-lock mode that holds the port for up to `MAX_LOCK` back-to-back transactions. An outstanding-transaction limiter that stops issue while `MAX_OUTSTANDING` responses are pending. Responses are routed back to masters by one-hot ID.

## Interface
- `N_MASTER`, 16: number of requesters; any value ≥2, not required to be a power of 2.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 64: write data width.
- `BE_WIDTH`, `DATA_WIDTH/8`: byte-enable width.
- `ID_WIDTH`, `N_MASTER`: one-hot transaction ID width.
- `MAX_OUTSTANDING`, 4: maximum accepted transactions awaiting `data_r_valid_i`; ≥1.
- `MAX_LOCK`, 8: maximum consecutive transactions per lock tenure; ≥1.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: reset.
- Master side (all `[N_MASTER]` vectors of the given width):
  - `data_req_i` in 1: request.
  - `data_add_i` in `ADDR_WIDTH`: address.
  - `data_wen_i` in 1: 1 = read, 0 = write.
  - `data_wdata_i` in `DATA_WIDTH`: write data.
  - `data_be_i` in `BE_WIDTH`: byte enables.
  - `data_ID_i` in `ID_WIDTH`: one-hot transaction ID.
  - `data_lock_i` in 1: request lock after this transaction.
  - `data_gnt_o` out 1: grant.
- Memory side:
  - `data_req_o` out 1: forwarded request.
  - `data_add_o` out `ADDR_WIDTH`: forwarded address.
  - `data_wen_o` out 1: forwarded read/write.
  - `data_wdata_o` out `DATA_WIDTH`: forwarded write data.
  - `data_be_o` out `BE_WIDTH`: forwarded byte enables.
  - `data_ID_o` out `ID_WIDTH`: forwarded ID.
  - `data_gnt_i` in 1: memory accepts.
- Response side:
  - `data_r_valid_i` in 1: response valid.
  - `data_r_ID_i` in `ID_WIDTH`: response ID.
  - `data_r_valid_o` out `N_MASTER`: per-master response valid.
- Status: `outstanding_o` out `$clog2(MAX_OUTSTANDING+1)`: pending count.

## Operation
- **Acceptance.** A transaction is accepted on the cycle where `data_req_o && data_gnt_i`. Every accepted read or write returns exactly one `data_r_valid_i`.
- **Eligibility.** Master k is eligible when `data_req_i[k]=1`, `count < MAX_OUTSTANDING`, and either the state is IDLE or the state is LOCKED with owner = k.
- **Selection.**
  - The winner is the first eligible master scanning k = ptr, ptr+1, … wrapping N_MASTER-1 → 0.
  - The winner's fields drive the memory outputs and `data_req_o=1`.
  - `data_gnt_o[winner] = data_gnt_i`. All other grants are 0.
  - With no eligible master, `data_req_o=0` and every `data_gnt_o` is 0. The other memory outputs are don't-care; drive them to 0.
- **Pointer.** On acceptance in IDLE, `ptr ← (winner+1) mod N_MASTER`. In LOCKED, `ptr` holds and is updated to `(owner+1) mod N_MASTER` on release.
- **Lock FSM, IDLE.** An accepted transaction with `data_lock_i[winner]=1` moves to LOCKED with `owner ← winner`, `lock_cnt ← 1`. If `MAX_LOCK=1`, stay in IDLE.
- **Lock FSM, LOCKED.** Return to IDLE on the first of these:
  - The owner has an accepted transaction with `data_lock_i=0`; that transaction completes, then release.
  - The owner has an accepted transaction that brings `lock_cnt` to `MAX_LOCK` (forced release).
  - `data_req_i[owner]=0` on any cycle; release takes effect next cycle.
  - Otherwise, each accepted transaction does `lock_cnt++`.
- **Outstanding counter.** Increment on accept, decrement on `data_r_valid_i`. When both happen in the same cycle, the count is unchanged. A decrement at 0 saturates at 0; this is an error condition and is checked by bench assertion.
- **Response routing.** `data_r_valid_o = data_r_valid_i ? data_r_ID_i[N_MASTER-1:0] : '0`. Routing is purely combinational and independent of state.

## Timing
- Request path is combinational: inputs → `data_req_o` and fields. `data_gnt_i` → `data_gnt_o` is a zero-cycle path.
- There is no combinational path from `data_gnt_i` or `data_r_valid_i` to `data_req_o`. The outstanding limit uses the registered `count`, so a response arriving while full unblocks issue on the next cycle.
- Response path latency is 0.
- **Reset values:** `ptr=0`, state IDLE, `owner=0`, `lock_cnt=0`, `count=0`, `outstanding_o=0`. The combinational outputs follow inputs under that state.
- **Reset mid-operation:** lock is dropped and the counter is cleared. Responses arriving after reset are still routed, and their decrements saturate at 0.

## Structure
- Package `l2_arb_pkg`: `lock_state_e` (IDLE, LOCKED), and a width function for `ptr` and the owner index (`$clog2(N_MASTER)`, min 1).
- Sub-module `rr_prio_select`: purely combinational. Inputs are an eligibility vector and `ptr`. Outputs are a one-hot winner, the winner index, and a valid flag, using a double-width masked priority encode.
- Top level holds the FSM, pointer, counters and the output mux.

## Test plan
- **Round-robin fairness.** Masters 0, 3, 5 request continuously, `data_gnt_i=1`, `MAX_OUTSTANDING` large → grants 0, 3, 5, 0, 3, 5; `ptr` wraps correctly for `N_MASTER=5` (4 → 0).
- **Lock tenure.** M2 issues 3 transactions with lock=1, 1, 0 while M1 requests → M2 is granted 3 in a row, then M1; no M1 grant during the tenure.
- **Forced release.** `MAX_LOCK=4`, M2 holds lock=1 → 4 M2 grants, then M3 is granted; `ptr=3` after release.
- **Outstanding limit.** `MAX_OUTSTANDING=2`, no responses → 2 accepts, then `data_req_o=0`. One `data_r_valid_i` → `data_req_o=1` exactly one cycle later. Simultaneous accept and response at count 1 → count stays 1.
- **Memory stall.** `data_gnt_i=0` for 5 cycles with M4 requesting → `data_req_o=1`, `data_gnt_o=0`, `ptr` unchanged, no counter change.
- **Response routing and reset.** `data_r_ID_i=16'h0040` with valid → `data_r_valid_o=16'h0040`. `rst_n` pulsed mid-lock with count 3 → IDLE and count 0; a later response leaves count at 0.
